// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master arbiter slice.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SLV_IDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } arb_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed for a down-counter that starts at n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping.
module spi_rr_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [SLV_IDX_W-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]   grant_oh,
    output logic [SLV_IDX_W-1:0] grant_idx,
    output logic                 any_req
);

    // Scan offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        int j;
        j         = 0;
        grant_oh  = '0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[j]) begin
                grant_oh    = '0;
                grant_oh[j] = 1'b1;
                grant_idx   = SLV_IDX_W'(j);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one byte-wide SPI engine between NUM_REQ clients with round-robin
// arbitration and owns the chip selects with setup/hold/gap timing.
module spi_master_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int NUM_SLAVES = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int CS_GAP     = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*SPI_BYTE_W-1:0]   req_data,
    input  logic [NUM_REQ*SLV_IDX_W-1:0]    req_slave,
    output logic [NUM_REQ-1:0]              ack,
    output logic                            err,
    output logic                            spi_start,
    output logic [SPI_BYTE_W-1:0]           spi_data,
    input  logic                            spi_done,
    output logic [NUM_SLAVES-1:0]           cs,
    output logic [SLV_IDX_W-1:0]            grant_id,
    output logic                            busy
);

    localparam int CNT_W = cnt_width(max3(CS_SETUP, CS_HOLD, CS_GAP));
    localparam int TMO_W = cnt_width(TIMEOUT);

    arb_state_t state_reg, state_next;

    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [TMO_W-1:0]      tmo_reg, tmo_next;
    logic [SLV_IDX_W-1:0]  grant_id_reg, grant_id_next;
    logic [SLV_IDX_W-1:0]  slave_reg, slave_next;
    logic [SLV_IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [SPI_BYTE_W-1:0] spi_data_reg, spi_data_next;
    logic [NUM_SLAVES-1:0] cs_reg, cs_next;
    logic [NUM_REQ-1:0]    ack_reg, ack_next;
    logic                  err_reg, err_next;
    logic                  spi_start_reg, spi_start_next;
    logic                  busy_reg, busy_next;

    logic [NUM_REQ-1:0]    arb_grant_oh;
    logic [SLV_IDX_W-1:0]  arb_idx;
    logic                  arb_any;
    logic [SPI_BYTE_W-1:0] arb_data;
    logic [SLV_IDX_W-1:0]  arb_slave;
    logic                  slave_bad;

    logic                  cs_active;
    logic [SLV_IDX_W-1:0]  cs_slave;
    logic                  ack_fire;
    logic [SLV_IDX_W-1:0]  ack_idx;

    logic [NUM_REQ-1:0][SPI_BYTE_W-1:0] data_terms;
    logic [NUM_REQ-1:0][SLV_IDX_W-1:0]  slave_terms;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr_reg),
        .grant_oh  (arb_grant_oh),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    // AND-OR select of the winning client's byte and slave index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_mux
        assign data_terms[gi]  = arb_grant_oh[gi] ? req_data[gi*SPI_BYTE_W +: SPI_BYTE_W] : '0;
        assign slave_terms[gi] = arb_grant_oh[gi] ? req_slave[gi*SLV_IDX_W +: SLV_IDX_W] : '0;
    end

    always_comb begin
        arb_data  = '0;
        arb_slave = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_data  = arb_data | data_terms[i];
            arb_slave = arb_slave | slave_terms[i];
        end
    end

    assign slave_bad = (int'(arb_slave) >= NUM_SLAVES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Done takes priority over an expiring timeout in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (arb_any) state_next = slave_bad ? GAP : SETUP;
            SETUP:   if (cnt_reg == '0) state_next = XFER;
            XFER: begin
                if (spi_done)            state_next = HOLD;
                else if (tmo_reg == '0)  state_next = GAP;
            end
            HOLD:    if (cnt_reg == '0) state_next = GAP;
            GAP:     if (cnt_reg == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            case (state_next)
                SETUP:   cnt_next = CNT_W'(CS_SETUP - 1);
                HOLD:    cnt_next = CNT_W'(CS_HOLD - 1);
                GAP:     cnt_next = CNT_W'(CS_GAP - 1);
                default: cnt_next = '0;
            endcase
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end

        tmo_next = tmo_reg;
        if (state_next == XFER && state_reg != XFER) begin
            tmo_next = TMO_W'(TIMEOUT - 1);
        end else if (state_reg == XFER && tmo_reg != '0) begin
            tmo_next = tmo_reg - TMO_W'(1);
        end

        grant_id_next = grant_id_reg;
        slave_next    = slave_reg;
        spi_data_next = spi_data_reg;
        if (state_reg == IDLE && arb_any) begin
            grant_id_next = arb_idx;
            slave_next    = arb_slave;
            spi_data_next = arb_data;
        end

        cs_active = (state_next == SETUP) || (state_next == XFER) || (state_next == HOLD);
        cs_slave  = (state_reg == IDLE) ? arb_slave : slave_reg;

        // Every entry into GAP completes a transaction; only the HOLD path is clean.
        ack_fire = (state_next == GAP) && (state_reg != GAP);
        ack_idx  = (state_reg == IDLE) ? arb_idx : grant_id_reg;
        err_next = ack_fire && (state_reg != HOLD);

        rr_ptr_next = rr_ptr_reg;
        if (ack_fire) begin
            rr_ptr_next = (ack_idx == SLV_IDX_W'(NUM_REQ - 1)) ? '0 : ack_idx + SLV_IDX_W'(1);
        end

        spi_start_next = (state_reg == SETUP) && (state_next == XFER);
        busy_next      = (state_next != IDLE);
    end

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_cs
        assign cs_next[gi] = !(cs_active && (cs_slave == SLV_IDX_W'(gi)));
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
        assign ack_next[gi] = ack_fire && (ack_idx == SLV_IDX_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            tmo_reg       <= '0;
            grant_id_reg  <= '0;
            slave_reg     <= '0;
            rr_ptr_reg    <= '0;
            spi_data_reg  <= '0;
            cs_reg        <= '1;
            ack_reg       <= '0;
            err_reg       <= 1'b0;
            spi_start_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            tmo_reg       <= tmo_next;
            grant_id_reg  <= grant_id_next;
            slave_reg     <= slave_next;
            rr_ptr_reg    <= rr_ptr_next;
            spi_data_reg  <= spi_data_next;
            cs_reg        <= cs_next;
            ack_reg       <= ack_next;
            err_reg       <= err_next;
            spi_start_reg <= spi_start_next;
            busy_reg      <= busy_next;
        end
    end

    assign ack       = ack_reg;
    assign err       = err_reg;
    assign spi_start = spi_start_reg;
    assign spi_data  = spi_data_reg;
    assign cs        = cs_reg;
    assign grant_id  = grant_id_reg;
    assign busy      = busy_reg;

endmodule
